// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD seven-segment display driver.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // 10^n, saturating at 10^19 so the result always fits in 64 bits.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n && i < 19; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Active-low seven-segment decoder for a single BCD digit; bit 6 = segment g.
module bcd_to_seven_seg (
  input  logic [3:0] bcd_val,
  output logic [6:0] seven_seg_val
);

  always_comb begin
    seven_seg_val = 7'h7F;
    case (bcd_val)
      4'd0: seven_seg_val = 7'h40;
      4'd1: seven_seg_val = 7'h79;
      4'd2: seven_seg_val = 7'h24;
      4'd3: seven_seg_val = 7'h30;
      4'd4: seven_seg_val = 7'h19;
      4'd5: seven_seg_val = 7'h12;
      4'd6: seven_seg_val = 7'h02;
      4'd7: seven_seg_val = 7'h78;
      4'd8: seven_seg_val = 7'h00;
      4'd9: seven_seg_val = 7'h10;
      default: seven_seg_val = 7'h7F;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving NUM_DIGITS
// active-low seven-segment displays with leading-zero blanking and overflow dashes.
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int unsigned BIN_WIDTH     = 8,
  parameter int unsigned NUM_DIGITS    = 3,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_WIDTH-1:0]         in_bin,
  output logic                         busy,
  output logic                         overflow,
  output logic [NUM_DIGITS-1:0][6:0]   hex
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [BIN_WIDTH-1:0]        bin_q, bin_nxt;
  logic [BCD_W-1:0]            bcd, bcd_nxt, bcd_adj;
  logic                        ovf_pend, ovf_pend_nxt;
  logic                        overflow_nxt;
  logic [NUM_DIGITS-1:0][6:0]  hex_nxt, seg_raw, seg_disp;

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_seven_seg u_dec (
      .bcd_val       (bcd[4*g +: 4]),
      .seven_seg_val (seg_raw[g])
    );
  end

  // Walk from the top digit down, blanking while every digit so far is zero.
  always_comb begin
    logic lead;
    lead     = 1'b1;
    seg_disp = seg_raw;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      lead = lead & (bcd[4*k +: 4] == 4'd0);
      if (ovf_pend) begin
        seg_disp[k] = SEG_DASH;
      end else if (BLANK_LEADING && lead && (k != 0)) begin
        seg_disp[k] = SEG_BLANK;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bin_nxt      = bin_q;
    bcd_nxt      = bcd;
    ovf_pend_nxt = ovf_pend;
    hex_nxt      = hex;
    overflow_nxt = overflow;
    case (state)
      IDLE: begin
        if (in_valid) begin
          bin_nxt      = in_bin;
          bcd_nxt      = '0;
          cnt_nxt      = CNT_W'(BIN_WIDTH);
          ovf_pend_nxt = (64'(in_bin) > MAX_VAL);
          state_nxt    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_nxt = bin_q << 1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        hex_nxt      = seg_disp;
        overflow_nxt = ovf_pend;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bin_q    <= '0;
      bcd      <= '0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      hex      <= {NUM_DIGITS{SEG_BLANK}};
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bin_q    <= bin_nxt;
      bcd      <= bcd_nxt;
      ovf_pend <= ovf_pend_nxt;
      overflow <= overflow_nxt;
      hex      <= hex_nxt;
      busy     <= (state_nxt != IDLE);
      in_ready <= (state_nxt == IDLE);
    end
  end

endmodule
